register_file_mp: RTL and testbench

Parametrised multi-port successor of the core integer register file: a configurable number of combinational read ports and synchronous write ports, with a hardware clear sequencer that zeroes every entry after reset. It serves the superscalar and multi-issue pipeline variants, sitting between decode (read) and writeback (write). An optional same-cycle write-to-read bypass is compiled in with a macro.

---
 rtl/register_file_mp_if.sv | 41 ++++
 rtl/register_file_mp.sv | 136 +++++++++++++
 tb/tb_register_file_mp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// register_file_mp_if
//   Bundles the read/write port signals of register_file_mp so that
//   decode/writeback logic and the register file connect through one port.
//
//   Parameters: XLEN (data width), NREGS (entries), NRD (read ports),
//               NWR (write ports). AW = $clog2(NREGS).
//
//   Signals:
//     we_i   [NWR]        per-port write enable
//     wa_i   [NWR*AW]     per-port write address, port p at [p*AW +: AW]
//     wd_i   [NWR*XLEN]   per-port write data,    port p at [p*XLEN +: XLEN]
//     ra_i   [NRD*AW]     per-port read address
//     rd_o   [NRD*XLEN]   per-port read data (combinational)
//     busy_o              high while the clear sequence runs
//
//   Modports: master (pipeline side), slave (register file side).
interface register_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]      we_i;
  logic [NWR*AW-1:0]   wa_i;
  logic [NWR*XLEN-1:0] wd_i;
  logic [NRD*AW-1:0]   ra_i;
  logic [NRD*XLEN-1:0] rd_o;
  logic                busy_o;

  modport master (
    output we_i, wa_i, wd_i, ra_i,
    input  rd_o, busy_o
  );

  modport slave (
    input  we_i, wa_i, wd_i, ra_i,
    output rd_o, busy_o
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port integer register file with NRD combinational read ports,
//   NWR synchronous write ports and a clear sequencer that zeroes every
//   entry, one per cycle, after reset.
//
//   Ports:
//     clk_i  clock, all state changes on the rising edge
//     rst_i  synchronous active-high reset; restarts the clear sequence
//     bus    register_file_mp_if.slave (we/wa/wd/ra in, rd/busy out)
//
//   Behaviour notes:
//     - While clearing (busy_o = 1) writes are dropped and all reads return 0.
//     - Write collision on the same address: the higher-numbered port wins.
//     - ZERO_REG = 1: entry 0 reads 0 and ignores writes.
//     - Addresses >= NREGS: writes dropped, reads return 0.
//
//   Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//   to read ports whose address matches an accepted write.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  register_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cidx_reg, cidx_next;
  logic            clear_we;
  logic            busy;

  logic [XLEN-1:0] mem [NREGS];

  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];
  logic            wok  [NWR];   // write accepted this cycle
  logic [AW-1:0]   ra   [NRD];
  logic [XLEN-1:0] rval [NRD];

  // Address lies inside the array and is not the hardwired zero entry.
  function automatic logic addr_writable(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_CLEAR;
      cidx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cidx_reg  <= cidx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cidx_next  = cidx_reg;
    clear_we   = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clear_we = 1'b1;
        if (int'(cidx_reg) == NREGS - 1) begin
          state_next = ST_IDLE;
          cidx_next  = '0;
        end else begin
          cidx_next = cidx_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg == ST_CLEAR);
  assign bus.busy_o  = busy;

  // ---------------------------------------------------------------------
  // Write ports
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
    assign wa[gi]  = bus.wa_i[gi*AW +: AW];
    assign wd[gi]  = bus.wd_i[gi*XLEN +: XLEN];
    // rst_i also blocks writes so a reset edge never lands a stray write.
    assign wok[gi] = !busy && !rst_i && bus.we_i[gi] && addr_writable(wa[gi]);
  end

  // Clear writes are gated by rst_i so a held reset does not advance.
  // Write ports are visited in ascending order; the later non-blocking
  // assignment wins, which gives the higher port priority on collision.
  always_ff @(posedge clk_i) begin
    if (clear_we && !rst_i) begin
      mem[cidx_reg] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wok[p]) begin
          mem[wa[p]] <= wd[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    assign ra[gi] = bus.ra_i[gi*AW +: AW];

    always_comb begin
      rval[gi] = '0;
      if (!busy && addr_writable(ra[gi])) begin
        rval[gi] = mem[ra[gi]];
`ifdef REGFILE_BYPASS_EN
        // wok already excludes busy, zero entry and out-of-range addresses.
        for (int p = 0; p < NWR; p++) begin
          if (wok[p] && (wa[p] == ra[gi])) begin
            rval[gi] = wd[p];
          end
        end
`endif
      end
    end

    assign bus.rd_o[gi*XLEN +: XLEN] = rval[gi];
  end
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int a_done;
  int b_done;

  register_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
  register_file_mp_if #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(1)) bus_b ();

  register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a.slave)
  );

  register_file_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(1), .ZERO_REG(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input int port, input logic [4:0] addr, input logic [31:0] data);
    bus_a.we_i[port]          = 1'b1;
    bus_a.wa_i[port*5 +: 5]   = addr;
    bus_a.wd_i[port*32 +: 32] = data;
  endtask

  function automatic logic [31:0] a_rd(input int port);
    return bus_a.rd_o[port*32 +: 32];
  endfunction

  function automatic logic [31:0] b_rd(input int port);
    return bus_b.rd_o[port*32 +: 32];
  endfunction

  // Counts edges until both instances leave busy; drops held writes as soon
  // as each one reports idle so nothing lands after the clear.
  task automatic wait_clear();
    a_done = 0;
    b_done = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      if (!bus_b.busy_o && b_done == 0) begin
        b_done = cyc;
        bus_b.we_i = '0;
      end
      if (!bus_a.busy_o) begin
        a_done = cyc;
        bus_a.we_i = '0;
        break;
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus_a.we_i = '0; bus_a.wa_i = '0; bus_a.wd_i = '0; bus_a.ra_i = '0;
    bus_b.we_i = '0; bus_b.wa_i = '0; bus_b.wd_i = '0; bus_b.ra_i = '0;
    tick();

    // Reset state
    check_eq("rst_busy_a", 32'(bus_a.busy_o), 32'd1);
    check_eq("rst_busy_b", 32'(bus_b.busy_o), 32'd1);
    check_eq("rst_rd_a0", a_rd(0), 32'h0);

    // Release reset with writes held during the clear
    rst = 1'b0;
    a_wr(0, 5'd9, 32'h12345678);
    bus_b.we_i = 1'b1; bus_b.wa_i = 5'd5; bus_b.wd_i = 32'h00000055;
    wait_clear();
    check_eq("clear_latency_a", 32'(a_done), 32'd32);
    check_eq("clear_latency_b", 32'(b_done), 32'd24);
    check_eq("idle_busy_a", 32'(bus_a.busy_o), 32'd0);

    // Every entry reads zero after the clear (x9 had a write during busy)
    for (int i = 0; i < 32; i++) begin
      bus_a.ra_i[4:0] = 5'(i);
      #1;
      check_eq($sformatf("clr_x%0d", i), a_rd(0), 32'h0);
    end
    bus_b.ra_i[4:0] = 5'd5;
    #1;
    check_eq("b_busy_write_dropped", b_rd(0), 32'h0);

    // Port 0 write then read on both ports
    a_wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    bus_a.we_i = '0;
    bus_a.ra_i = {5'd5, 5'd5};
    #1;
    check_eq("x5_rd0", a_rd(0), 32'hDEADBEEF);
    check_eq("x5_rd1", a_rd(1), 32'hDEADBEEF);

    // Write to x0 with same-cycle read; x0 never changes
    a_wr(0, 5'd0, 32'hFFFFFFFF);
    bus_a.ra_i[4:0] = 5'd0;
    #1;
    check_eq("x0_same_cycle", a_rd(0), 32'h0);
    tick();
    bus_a.we_i = '0;
    #1;
    check_eq("x0_after", a_rd(0), 32'h0);

    // Collision on x7: port 1 wins
    a_wr(0, 5'd7, 32'h11111111);
    a_wr(1, 5'd7, 32'h22222222);
    tick();
    bus_a.we_i = '0;
    bus_a.ra_i[4:0] = 5'd7;
    #1;
    check_eq("collision_x7", a_rd(0), 32'h22222222);

    // Same-cycle write/read of x3 on read port 1
    a_wr(0, 5'd3, 32'hA5A5A5A5);
    bus_a.ra_i[9:5] = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("x3_same_cycle", a_rd(1), 32'hA5A5A5A5);
`else
    check_eq("x3_same_cycle", a_rd(1), 32'h0);
`endif
    tick();
    bus_a.we_i = '0;
    #1;
    check_eq("x3_next_cycle", a_rd(1), 32'hA5A5A5A5);

    // NREGS = 24: out-of-range write/read
    bus_b.we_i = 1'b1; bus_b.wa_i = 5'd30; bus_b.wd_i = 32'hCAFEF00D;
    bus_b.ra_i = {5'd23, 5'd30};
    #1;
    check_eq("b_x30_same_cycle", b_rd(0), 32'h0);
    tick();
    bus_b.wa_i = 5'd23; bus_b.wd_i = 32'h00000023;
    tick();
    bus_b.we_i = '0;
    #1;
    check_eq("b_x30_read", b_rd(0), 32'h0);
    check_eq("b_x23_read", b_rd(1), 32'h00000023);
    bus_b.ra_i[4:0] = 5'd22;
    #1;
    check_eq("b_x22_unchanged", b_rd(0), 32'h0);

    // Reset, then re-assert at clear index 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus_a.ra_i[4:0] = 5'd7;
    #1;
    check_eq("mid_clear_busy", 32'(bus_a.busy_o), 32'd1);
    check_eq("mid_clear_rd_forced", a_rd(0), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_wr(1, 5'd20, 32'h00000BAD);
    wait_clear();
    check_eq("reclear_latency_a", 32'(a_done), 32'd32);
    bus_a.ra_i = {5'd5, 5'd7};
    #1;
    check_eq("reclear_x7", a_rd(0), 32'h0);
    check_eq("reclear_x5", a_rd(1), 32'h0);
    bus_a.ra_i = {5'd20, 5'd3};
    #1;
    check_eq("reclear_x3", a_rd(0), 32'h0);
    check_eq("reclear_x20", a_rd(1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
